pong_physics_engine: RTL and testbench

//  Per-frame game-state updater for the Pong display design: on each frame tick it moves two

---
 rtl/pong_physics_engine_pkg.sv | 104 ++++++++++
 rtl/pong_physics_engine_if.sv | 30 +++
 rtl/pong_physics_engine_paddle_ctrl.sv | 39 +++
 rtl/pong_physics_engine.sv | 207 ++++++++++++++++++++
 tb/tb_pong_physics_engine.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_physics_engine_pkg.sv
// Shared constants, types and helpers for the Pong physics engine.
// Holds screen geometry, FSM encoding, button bit indices and small math helpers.
package pong_physics_engine_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int COORD_W    = 12;
    localparam int VEL_W      = 8;
    localparam int NUM_BALLS  = 2;
    localparam int BALL_SIZE  = 32;
    localparam int PAD_W      = 8;
    localparam int PAD_H      = 80;
    localparam int PAD_OFS    = 40;
    localparam int PAD_SPEED  = 6;
    localparam int INIT_SPEED = 5;
    localparam int MAX_SPEED  = 12;
    localparam int SCORE_W    = 4;

    localparam int IDX_W = 2;
    localparam int SW    = COORD_W + 2;

    localparam int BTN_P1_DN = 3;
    localparam int BTN_P1_UP = 2;
    localparam int BTN_P2_DN = 1;
    localparam int BTN_P2_UP = 0;

    localparam int PAD_Y0    = (SCREEN_H - PAD_H) / 2;
    localparam int PAD_Y_MAX = SCREEN_H - PAD_H;
    localparam int BALL_X0   = (SCREEN_W - BALL_SIZE) / 2;
    localparam int P1_FACE   = PAD_OFS + PAD_W;
    localparam int P2_X      = SCREEN_W - PAD_OFS - PAD_W;
    localparam int P2_SNAP   = P2_X - BALL_SIZE;

    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic signed [VEL_W-1:0]   vel_t;
    typedef logic signed [SW-1:0]      scoord_t;
    typedef logic [SCORE_W-1:0]        score_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PADDLE,
        ST_MOVE,
        ST_WALL,
        ST_HIT,
        ST_DONE
    } state_t;

    function automatic logic [NUM_BALLS*COORD_W-1:0] init_x();
        logic [NUM_BALLS*COORD_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_BALLS; i++)
            v[i*COORD_W +: COORD_W] = coord_t'(BALL_X0);
        return v;
    endfunction

    function automatic logic [NUM_BALLS*COORD_W-1:0] init_y();
        logic [NUM_BALLS*COORD_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_BALLS; i++)
            v[i*COORD_W +: COORD_W] = coord_t'(i * (SCREEN_H / NUM_BALLS));
        return v;
    endfunction

    // Even balls serve right, odd balls serve left; all start moving down.
    function automatic logic [NUM_BALLS*VEL_W-1:0] init_vx();
        logic [NUM_BALLS*VEL_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_BALLS; i++)
            v[i*VEL_W +: VEL_W] = (i % 2 == 0) ? vel_t'(INIT_SPEED)
                                               : -vel_t'(INIT_SPEED);
        return v;
    endfunction

    function automatic logic [NUM_BALLS*VEL_W-1:0] init_vy();
        logic [NUM_BALLS*VEL_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_BALLS; i++)
            v[i*VEL_W +: VEL_W] = vel_t'(INIT_SPEED);
        return v;
    endfunction

    function automatic score_t sat_inc(score_t s);
        return (&s) ? s : s + 1'b1;
    endfunction

    // Raise magnitude by one up to MAX_SPEED, keeping the sign.
    function automatic vel_t speed_up(vel_t v);
        vel_t m;
        m = v[VEL_W-1] ? -v : v;
        if (m < vel_t'(MAX_SPEED))
            m = m + vel_t'(1);
        return v[VEL_W-1] ? -m : m;
    endfunction

    // Axis-aligned overlap of the ball box against a paddle box.
    function automatic logic aabb(coord_t bx, coord_t by,
                                  coord_t px, coord_t py);
        return (bx < px + coord_t'(PAD_W)) &&
               (bx + coord_t'(BALL_SIZE) > px) &&
               (by < py + coord_t'(PAD_H)) &&
               (by + coord_t'(BALL_SIZE) > py);
    endfunction

endpackage

// File: rtl/pong_physics_engine_if.sv
// Frame-tick / button inputs and object-state outputs of the physics engine.
// master: game/renderer side; slave: the engine.
interface pong_physics_engine_if;
    import pong_physics_engine_pkg::*;

    logic                         frame_tick;
    logic [3:0]                   button;
    logic [NUM_BALLS*COORD_W-1:0] ball_x;
    logic [NUM_BALLS*COORD_W-1:0] ball_y;
    coord_t                       p1_y;
    coord_t                       p2_y;
    score_t                       score1;
    score_t                       score2;
    logic                         busy;
    logic                         update_done;
    logic                         overrun;

    modport master (
        output frame_tick, button,
        input  ball_x, ball_y, p1_y, p2_y, score1, score2,
        input  busy, update_done, overrun
    );

    modport slave (
        input  frame_tick, button,
        output ball_x, ball_y, p1_y, p2_y, score1, score2,
        output busy, update_done, overrun
    );

endinterface

// File: rtl/pong_physics_engine_paddle_ctrl.sv
// One paddle: registered top-edge position, moved by PAD_SPEED on step_i.
// Ports: clk, rst_n, step_i, up_i, dn_i (active-high), y_o (clamped top edge).
module pong_paddle_ctrl
    import pong_physics_engine_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step_i,
    input  logic   up_i,
    input  logic   dn_i,
    output coord_t y_o
);

    coord_t y_q, y_d;

    // Up wins when both directions are pressed.
    always_comb begin
        y_d = y_q;
        if (step_i) begin
            if (up_i)
                y_d = (y_q >= coord_t'(PAD_SPEED))
                    ? y_q - coord_t'(PAD_SPEED) : '0;
            else if (dn_i)
                y_d = (y_q < coord_t'(PAD_Y_MAX - PAD_SPEED))
                    ? y_q + coord_t'(PAD_SPEED)
                    : coord_t'(PAD_Y_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y_q <= coord_t'(PAD_Y0);
        else
            y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_physics_engine.sv
// Per-frame Pong state updater: paddles, NUM_BALLS balls, wall/paddle bounce, scores.
// Ports: clk, rst_n (async, active-low), io (slave modport). Option macro: SPEEDUP_EN.
module pong_physics_engine
    import pong_physics_engine_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    pong_physics_engine_if.slave io
);

    localparam int BXW = NUM_BALLS * COORD_W;
    localparam int BVW = NUM_BALLS * VEL_W;

    localparam logic [BXW-1:0] BX0 = init_x();
    localparam logic [BXW-1:0] BY0 = init_y();
    localparam logic [BVW-1:0] VX0 = init_vx();
    localparam logic [BVW-1:0] VY0 = init_vy();

    localparam scoord_t X_LIM = scoord_t'(SCREEN_W - BALL_SIZE);
    localparam scoord_t Y_LIM = scoord_t'(SCREEN_H - BALL_SIZE);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BXW-1:0]   bx_q, bx_d, by_q, by_d;
    logic [BVW-1:0]   vx_q, vx_d, vy_q, vy_d;
    scoord_t          nx_q, nx_d, ny_q, ny_d;
    logic             goal_q, goal_d;
    score_t           s1_q, s1_d, s2_q, s2_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;

    coord_t cx, cy, nx_c, ny_c;
    vel_t   cvx, cvy, nvx, nvy;
    coord_t p1_y, p2_y;
    logic   pad_step, tow1, hit, last;

    assign cx   = bx_q[idx_q*COORD_W +: COORD_W];
    assign cy   = by_q[idx_q*COORD_W +: COORD_W];
    assign cvx  = vel_t'(vx_q[idx_q*VEL_W +: VEL_W]);
    assign cvy  = vel_t'(vy_q[idx_q*VEL_W +: VEL_W]);
    assign last = (idx_q == IDX_W'(NUM_BALLS - 1));

    assign pad_step = (state_q == ST_PADDLE);

    pong_paddle_ctrl u_pad1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_i (pad_step),
        .up_i   (~io.button[BTN_P1_UP]),
        .dn_i   (~io.button[BTN_P1_DN]),
        .y_o    (p1_y)
    );

    pong_paddle_ctrl u_pad2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .step_i (pad_step),
        .up_i   (~io.button[BTN_P2_UP]),
        .dn_i   (~io.button[BTN_P2_DN]),
        .y_o    (p2_y)
    );

    // Per-ball temporaries default to the current ball's state and are
    // written back unconditionally, so untouched states leave it intact.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bx_d    = bx_q;
        by_d    = by_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        goal_d  = goal_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | (io.frame_tick & (state_q != ST_IDLE));
        nx_c    = cx;
        ny_c    = cy;
        nvx     = cvx;
        nvy     = cvy;
        tow1    = cvx[VEL_W-1];
        hit     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (io.frame_tick) begin
                    state_d = ST_PADDLE;
                    idx_d   = '0;
                end
            end
            ST_PADDLE: begin
                state_d = ST_MOVE;
            end
            ST_MOVE: begin
                nx_d    = scoord_t'({2'b00, cx}) + scoord_t'(cvx);
                ny_d    = scoord_t'({2'b00, cy}) + scoord_t'(cvy);
                state_d = ST_WALL;
            end
            ST_WALL: begin
                ny_c = ny_q[COORD_W-1:0];
                if (ny_q[SW-1]) begin
                    ny_c = '0;
                    nvy  = -cvy;
                end else if (ny_q > Y_LIM) begin
                    ny_c = coord_t'(SCREEN_H - BALL_SIZE);
                    nvy  = -cvy;
                end
                nx_c   = nx_q[COORD_W-1:0];
                goal_d = 1'b1;
                if (nx_q[SW-1]) begin
                    s2_d = sat_inc(s2_q);
                    nvx  = -vel_t'(INIT_SPEED);
                end else if (nx_q > X_LIM) begin
                    s1_d = sat_inc(s1_q);
                    nvx  = vel_t'(INIT_SPEED);
                end else begin
                    goal_d = 1'b0;
                end
                // Serve: recentre x, keep vertical direction, restore speed.
                if (goal_d) begin
                    nx_c = coord_t'(BALL_X0);
                    nvy  = nvy[VEL_W-1] ? -vel_t'(INIT_SPEED)
                                        : vel_t'(INIT_SPEED);
                end
                state_d = ST_HIT;
            end
            ST_HIT: begin
                if (!goal_q) begin
                    hit = tow1 ? aabb(cx, cy, coord_t'(PAD_OFS), p1_y)
                               : aabb(cx, cy, coord_t'(P2_X), p2_y);
                end
                if (hit) begin
`ifdef SPEEDUP_EN
                    nvx = speed_up(-cvx);
                    nvy = speed_up(cvy);
`else
                    nvx = -cvx;
`endif
                    nx_c = tow1 ? coord_t'(P1_FACE) : coord_t'(P2_SNAP);
                end
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_MOVE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bx_d[idx_q*COORD_W +: COORD_W] = nx_c;
        by_d[idx_q*COORD_W +: COORD_W] = ny_c;
        vx_d[idx_q*VEL_W +: VEL_W]     = nvx;
        vy_d[idx_q*VEL_W +: VEL_W]     = nvy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bx_q    <= BX0;
            by_q    <= BY0;
            vx_q    <= VX0;
            vy_q    <= VY0;
            nx_q    <= '0;
            ny_q    <= '0;
            goal_q  <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            goal_q  <= goal_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign io.ball_x      = bx_q;
    assign io.ball_y      = by_q;
    assign io.p1_y        = p1_y;
    assign io.p2_y        = p2_y;
    assign io.score1      = s1_q;
    assign io.score2      = s2_q;
    assign io.busy        = (state_q != ST_IDLE);
    assign io.update_done = done_q;
    assign io.overrun     = ovr_q;

endmodule

// File: tb/tb_pong_physics_engine.sv
// Self-checking bench for pong_physics_engine: frame-level reference model
// feeding a scoreboard, plus directed latency, clamp, overrun and reset tests.
module tb_pong_physics_engine;
    import pong_physics_engine_pkg::*;

    localparam int NB   = NUM_BALLS;
    localparam int SMAX = (1 << SCORE_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pong_physics_engine_if bus();

    pong_physics_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    typedef struct {
        logic [NB*COORD_W-1:0] bx;
        logic [NB*COORD_W-1:0] by;
        int p1, p2, s1, s2;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    int mx[NB], my[NB], mvx[NB], mvy[NB];
    int mp1, mp2, ms1, ms2;

    function automatic int bump(int v);
`ifdef SPEEDUP_EN
        int m;
        m = (v < 0) ? -v : v;
        if (m < MAX_SPEED) m = m + 1;
        return (v < 0) ? -m : m;
`else
        return v;
`endif
    endfunction

    function automatic bit ovl(int bx, int by, int px, int py);
        return (bx < px + PAD_W) && (bx + BALL_SIZE > px) &&
               (by < py + PAD_H) && (by + BALL_SIZE > py);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]  = (SCREEN_W - BALL_SIZE) / 2;
            my[i]  = i * (SCREEN_H / NB);
            mvx[i] = (i % 2 == 0) ? INIT_SPEED : -INIT_SPEED;
            mvy[i] = INIT_SPEED;
        end
        mp1 = (SCREEN_H - PAD_H) / 2;
        mp2 = mp1;
        ms1 = 0;
        ms2 = 0;
        sb.delete();
    endtask

    task automatic step_pad(inout int p, input bit up, input bit dn);
        if (up)      p = (p - PAD_SPEED < 0) ? 0 : p - PAD_SPEED;
        else if (dn) p = (p + PAD_SPEED > SCREEN_H - PAD_H)
                         ? SCREEN_H - PAD_H : p + PAD_SPEED;
    endtask

    task automatic model_frame(input logic [3:0] b);
        exp_t e;
        step_pad(mp1, !b[2], !b[3]);
        step_pad(mp2, !b[0], !b[1]);
        for (int i = 0; i < NB; i++) begin
            int nx, ny;
            bit goal;
            nx = mx[i] + mvx[i];
            ny = my[i] + mvy[i];
            goal = 0;
            if (ny < 0) begin
                my[i] = 0; mvy[i] = -mvy[i];
            end else if (ny + BALL_SIZE > SCREEN_H) begin
                my[i] = SCREEN_H - BALL_SIZE; mvy[i] = -mvy[i];
            end else begin
                my[i] = ny;
            end
            if (nx < 0) begin
                if (ms2 < SMAX) ms2++;
                goal = 1; mvx[i] = -INIT_SPEED;
            end else if (nx + BALL_SIZE > SCREEN_W) begin
                if (ms1 < SMAX) ms1++;
                goal = 1; mvx[i] = INIT_SPEED;
            end
            if (goal) begin
                mx[i]  = (SCREEN_W - BALL_SIZE) / 2;
                mvy[i] = (mvy[i] < 0) ? -INIT_SPEED : INIT_SPEED;
            end else begin
                mx[i] = nx;
                if (mvx[i] < 0 && ovl(mx[i], my[i], PAD_OFS, mp1)) begin
                    mvx[i] = bump(-mvx[i]);
                    mvy[i] = bump(mvy[i]);
                    mx[i]  = PAD_OFS + PAD_W;
                end else if (mvx[i] > 0 &&
                             ovl(mx[i], my[i], SCREEN_W - PAD_OFS - PAD_W, mp2)) begin
                    mvx[i] = bump(-mvx[i]);
                    mvy[i] = bump(mvy[i]);
                    mx[i]  = SCREEN_W - PAD_OFS - PAD_W - BALL_SIZE;
                end
            end
        end
        for (int i = 0; i < NB; i++) begin
            e.bx[i*COORD_W +: COORD_W] = COORD_W'(mx[i]);
            e.by[i*COORD_W +: COORD_W] = COORD_W'(my[i]);
        end
        e.p1 = mp1; e.p2 = mp2; e.s1 = ms1; e.s2 = ms2;
        sb.push_back(e);
    endtask

    task automatic check_frame();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: update_done with nothing expected");
            return;
        end
        e = sb.pop_front();
        if (bus.ball_x !== e.bx) begin
            n_fail++;
            $display("FAIL ball_x got %h want %h", bus.ball_x, e.bx);
        end
        n_tests++;
        if (bus.ball_y !== e.by) begin
            n_fail++;
            $display("FAIL ball_y got %h want %h", bus.ball_y, e.by);
        end
        n_tests++;
        if (bus.p1_y !== COORD_W'(e.p1)) begin
            n_fail++;
            $display("FAIL p1_y got %0d want %0d", bus.p1_y, e.p1);
        end
        n_tests++;
        if (bus.p2_y !== COORD_W'(e.p2)) begin
            n_fail++;
            $display("FAIL p2_y got %0d want %0d", bus.p2_y, e.p2);
        end
        n_tests++;
        if (bus.score1 !== SCORE_W'(e.s1)) begin
            n_fail++;
            $display("FAIL score1 got %0d want %0d", bus.score1, e.s1);
        end
        n_tests++;
        if (bus.score2 !== SCORE_W'(e.s2)) begin
            n_fail++;
            $display("FAIL score2 got %0d want %0d", bus.score2, e.s2);
        end
    endtask

    // Issue one tick, wait (bounded) for update_done, then score the frame.
    task automatic run_frame(input logic [3:0] b, output int lat);
        bus.button     = b;
        bus.frame_tick = 1'b1;
        model_frame(b);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            bus.frame_tick = 1'b0;
            if (bus.update_done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: no update_done in 40 cycles");
            sb.delete();
        end else begin
            check_frame();
        end
    endtask

    task automatic test_reset();
        logic [NB*COORD_W-1:0] ex, ey;
        for (int i = 0; i < NB; i++) begin
            ex[i*COORD_W +: COORD_W] = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
            ey[i*COORD_W +: COORD_W] = COORD_W'(i * (SCREEN_H / NB));
        end
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.button = 4'hF;
        model_reset();
        #12;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.update_done !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags got %b%b%b want 000",
                     bus.busy, bus.update_done, bus.overrun);
        end
        n_tests++;
        if (bus.ball_x !== ex) begin
            n_fail++;
            $display("FAIL rst_ball_x got %h want %h", bus.ball_x, ex);
        end
        n_tests++;
        if (bus.ball_y !== ey) begin
            n_fail++;
            $display("FAIL rst_ball_y got %h want %h", bus.ball_y, ey);
        end
        n_tests++;
        if (bus.p1_y !== 12'd200 || bus.p2_y !== 12'd200) begin
            n_fail++;
            $display("FAIL rst_paddles got %0d/%0d want 200/200", bus.p1_y, bus.p2_y);
        end
        n_tests++;
        if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_scores got %0d/%0d want 0/0", bus.score1, bus.score2);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_first_frame();
        int lat;
        run_frame(4'hF, lat);
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL latency got %0d want 8", lat);
        end
        n_tests++;
        if (bus.ball_x[0 +: COORD_W] !== 12'd309 || bus.ball_y[0 +: COORD_W] !== 12'd5) begin
            n_fail++;
            $display("FAIL ball0_first got %0d,%0d want 309,5",
                     bus.ball_x[0 +: COORD_W], bus.ball_y[0 +: COORD_W]);
        end
        n_tests++;
        if (bus.ball_x[COORD_W +: COORD_W] !== 12'd299 ||
            bus.ball_y[COORD_W +: COORD_W] !== 12'd245) begin
            n_fail++;
            $display("FAIL ball1_first got %0d,%0d want 299,245",
                     bus.ball_x[COORD_W +: COORD_W], bus.ball_y[COORD_W +: COORD_W]);
        end
    endtask

    task automatic test_paddle_clamp();
        int lat;
        for (int k = 0; k < 40; k++) run_frame(4'b1011, lat);
        n_tests++;
        if (bus.p1_y !== 12'd0) begin
            n_fail++;
            $display("FAIL p1_top_clamp got %0d want 0", bus.p1_y);
        end
        run_frame(4'b1100, lat);
        n_tests++;
        if (bus.p2_y !== 12'd194) begin
            n_fail++;
            $display("FAIL p2_up_wins got %0d want 194", bus.p2_y);
        end
        for (int k = 0; k < 100; k++) run_frame(4'b0111, lat);
        n_tests++;
        if (bus.p1_y !== 12'd400) begin
            n_fail++;
            $display("FAIL p1_bot_clamp got %0d want 400", bus.p1_y);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        n_tests++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre got %b want 0", bus.overrun);
        end
        bus.button = 4'hF;
        bus.frame_tick = 1'b1;
        model_frame(4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        @(posedge clk); #1;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        dones = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus.update_done) begin
                dones++;
                if (dones == 1) check_frame();
            end
        end
        n_tests++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL b2b_done_count got %0d want 1", dones);
        end
        n_tests++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun got %b want 1", bus.overrun);
        end
        sb.delete();
    endtask

    // P1 tracks the leftmost incoming ball; P2 sits at the top so goals pile up.
    task automatic test_play();
        int lat, t, c, pc;
        logic [3:0] b;
        for (int k = 0; k < 3000; k++) begin
            t = -1;
            for (int i = 0; i < NB; i++)
                if (mvx[i] < 0 && (t < 0 || mx[i] < mx[t])) t = i;
            if (t < 0) t = 0;
            b = 4'b1110;
            c = my[t] + BALL_SIZE / 2;
            pc = mp1 + PAD_H / 2;
            if (c < pc - 4)      b[2] = 1'b0;
            else if (c > pc + 4) b[3] = 1'b0;
            if ($urandom_range(0, 15) == 0) b[3:2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) b[1:0] = 2'b01;
            run_frame(b, lat);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bus.button = 4'hF;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags got busy=%b ovr=%b want 0,0", bus.busy, bus.overrun);
        end
        n_tests++;
        if (bus.ball_x[0 +: COORD_W] !== 12'd304 || bus.ball_y[COORD_W +: COORD_W] !== 12'd240) begin
            n_fail++;
            $display("FAIL midrst_balls got x0=%0d y1=%0d want 304,240",
                     bus.ball_x[0 +: COORD_W], bus.ball_y[COORD_W +: COORD_W]);
        end
        n_tests++;
        if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0 || bus.p1_y !== 12'd200) begin
            n_fail++;
            $display("FAIL midrst_state got s1=%0d s2=%0d p1=%0d want 0,0,200",
                     bus.score1, bus.score2, bus.p1_y);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(4'hF, lat);
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL latency_after_rst got %0d want 8", lat);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_paddle_clamp();
        test_back_to_back();
        test_play();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
